// File: rtl/traffic_pkg.sv
// Shared lamp-state and fault-code types for the traffic lamp monitor.
// Lamp triples are packed {grn, ylw, red} throughout.
package traffic_pkg;

    typedef enum logic [1:0] {
        LampRed  = 2'd0,
        LampGrn  = 2'd1,
        LampYlw  = 2'd2,
        LampDark = 2'd3
    } lamp_e;

    typedef enum logic [2:0] {
        FaultNone     = 3'd0,
        FaultConflict = 3'd1,
        FaultLamp     = 3'd2,
        FaultSeq      = 3'd3,
        FaultYshort   = 3'd4,
        FaultStuck    = 3'd5
    } fault_e;

    // Multi-lamp patterns also decode to DARK; they are flagged separately.
    function automatic lamp_e lamp_decode(input logic [2:0] lamps);
        case (lamps)
            3'b001:  return LampRed;
            3'b100:  return LampGrn;
            3'b010:  return LampYlw;
            default: return LampDark;
        endcase
    endfunction

    function automatic logic lamp_multi(input logic [2:0] lamps);
        return (lamps[2] & lamps[1]) | (lamps[2] & lamps[0]) | (lamps[1] & lamps[0]);
    endfunction

    function automatic logic step_legal(input lamp_e prev_st, input lamp_e next_st);
        return (prev_st == next_st)
            || (prev_st == LampRed && next_st == LampGrn)
            || (prev_st == LampGrn && next_st == LampYlw)
            || (prev_st == LampYlw && next_st == LampRed);
    endfunction

endpackage

// File: rtl/lamp_dir_check.sv
// Per-direction lamp decode, transition legality and dwell counting.
// dwell_q counts consecutive samples ending at P that share P's decoded state.
module lamp_dir_check
    import traffic_pkg::*;
#(
    parameter int unsigned YMIN  = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       s_vld_i,
    input  logic       p_vld_i,
    input  logic       fm_i,
    input  logic [2:0] s_lamps_i,
    input  logic [2:0] p_lamps_i,
    output lamp_e      ph_o,
    output logic       multi_o,
    output logic       dark_o,
    output logic       seq_o,
    output logic       yshort_o
);

    localparam logic [CNT_W-1:0] DwellMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] YminC    = CNT_W'(YMIN);

    lamp_e            s_st, p_st;
    lamp_e            ph_d, ph_q;
    logic [CNT_W-1:0] dwell_d, dwell_q;
    logic             chk;

    always_comb begin
        s_st     = lamp_decode(s_lamps_i);
        p_st     = lamp_decode(p_lamps_i);
        chk      = s_vld_i && p_vld_i && !fm_i;
        multi_o  = s_vld_i && lamp_multi(s_lamps_i);
        dark_o   = s_vld_i && (s_lamps_i == 3'b000);
        seq_o    = chk && !step_legal(p_st, s_st);
        yshort_o = chk && (p_st == LampYlw) && (s_st == LampRed) && (dwell_q < YminC);
        ph_d     = en_i ? s_st : ph_q;
        dwell_d  = dwell_q;
        if (en_i && s_vld_i) begin
            if (!p_vld_i || s_st != p_st) begin
                dwell_d = CNT_W'(1);
            end else if (dwell_q != DwellMax) begin
                dwell_d = dwell_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q    <= LampDark;
            dwell_q <= '0;
        end else begin
            ph_q    <= ph_d;
            dwell_q <= dwell_d;
        end
    end

    assign ph_o = ph_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Traffic lamp monitor: samples both directions' lamps, checks conflicts, lamp
// patterns, sequencing, yellow dwell and stuck lamps, and keeps a sticky fault record.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned YMIN  = 3,
    parameter int unsigned TMAX  = 255,
    parameter int unsigned CNT_W = 8
) (
    input  logic       CK,
    input  logic       CLRN,
    input  logic       GRN1,
    input  logic       YLW1,
    input  logic       RED1,
    input  logic       GRN2,
    input  logic       YLW2,
    input  logic       RED2,
    input  logic       FM,
    input  logic       TEST,
    input  logic       ACK,
    output logic       FAULT,
    output logic [2:0] FAULT_CODE,
    output logic [3:0] FAULT_CNT,
    output logic [1:0] PH1,
    output logic [1:0] PH2
);

    localparam logic [CNT_W-1:0] TmaxC = CNT_W'(TMAX);

    logic             run_q;
    logic [5:0]       lamps;
    logic [5:0]       s_d, s_q, p_d, p_q;
    logic             s_vld_d, s_vld_q, p_vld_d, p_vld_q;
    logic [CNT_W-1:0] stuck_d, stuck_q;
    logic             stuck_evt, conflict;
    logic             fault_d, fault_q;
    fault_e           code_new, code_d, code_q;
    logic [3:0]       cnt_d, cnt_q;
    lamp_e            ph1, ph2;
    logic             multi1, multi2, dark1, dark2, seq1, seq2, ysh1, ysh2;

    assign lamps = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};

    // Release is taken through one flop, so sampling restarts on the second edge.
    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_comb begin
        s_d     = s_q;
        p_d     = p_q;
        s_vld_d = s_vld_q;
        p_vld_d = p_vld_q;
        if (run_q) begin
            s_d     = lamps;
            p_d     = s_q;
            s_vld_d = 1'b1;
            p_vld_d = s_vld_q;
        end
    end

    lamp_dir_check #(
        .YMIN  (YMIN),
        .CNT_W (CNT_W)
    ) u_dir1 (
        .clk_i     (CK),
        .rst_ni    (CLRN),
        .en_i      (run_q),
        .s_vld_i   (s_vld_q),
        .p_vld_i   (p_vld_q),
        .fm_i      (FM),
        .s_lamps_i (s_q[5:3]),
        .p_lamps_i (p_q[5:3]),
        .ph_o      (ph1),
        .multi_o   (multi1),
        .dark_o    (dark1),
        .seq_o     (seq1),
        .yshort_o  (ysh1)
    );

    lamp_dir_check #(
        .YMIN  (YMIN),
        .CNT_W (CNT_W)
    ) u_dir2 (
        .clk_i     (CK),
        .rst_ni    (CLRN),
        .en_i      (run_q),
        .s_vld_i   (s_vld_q),
        .p_vld_i   (p_vld_q),
        .fm_i      (FM),
        .s_lamps_i (s_q[2:0]),
        .p_lamps_i (p_q[2:0]),
        .ph_o      (ph2),
        .multi_o   (multi2),
        .dark_o    (dark2),
        .seq_o     (seq2),
        .yshort_o  (ysh2)
    );

    always_comb begin
        stuck_d   = stuck_q;
        stuck_evt = 1'b0;
        if (run_q && s_vld_q) begin
            if (FM || TEST || !p_vld_q || s_q != p_q) begin
                stuck_d = '0;
            end else if (stuck_q + CNT_W'(1) == TmaxC) begin
                stuck_evt = 1'b1;
                stuck_d   = '0;
            end else begin
                stuck_d = stuck_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        conflict = s_vld_q && (s_q[5] | s_q[4]) && (s_q[2] | s_q[1]);
        code_new = FaultNone;
        if (conflict) begin
            code_new = FaultConflict;
        end else if (multi1 || multi2 || (!FM && (dark1 || dark2))) begin
            code_new = FaultLamp;
        end else if (seq1 || seq2) begin
            code_new = FaultSeq;
        end else if (ysh1 || ysh2) begin
            code_new = FaultYshort;
        end else if (stuck_evt) begin
            code_new = FaultStuck;
        end
    end

    // A new event outranks ACK; the stored code is only replaced when clear or acked.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        if (run_q) begin
            if (code_new != FaultNone) begin
                fault_d = 1'b1;
                if (!fault_q || ACK) begin
                    code_d = code_new;
                end
                if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else if (ACK) begin
                fault_d = 1'b0;
                code_d  = FaultNone;
            end
        end
    end

    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            s_q     <= '0;
            p_q     <= '0;
            s_vld_q <= 1'b0;
            p_vld_q <= 1'b0;
            stuck_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FaultNone;
            cnt_q   <= '0;
        end else begin
            s_q     <= s_d;
            p_q     <= p_d;
            s_vld_q <= s_vld_d;
            p_vld_q <= p_vld_d;
            stuck_q <= stuck_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign FAULT      = fault_q;
    assign FAULT_CODE = code_q;
    assign FAULT_CNT  = cnt_q;
    assign PH1        = ph1;
    assign PH2        = ph2;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed scenarios plus random lamp traffic,
// checked every cycle against a sample-history reference model.
module tb_traffic_lamp_monitor;

    localparam int unsigned YMIN  = 3;
    localparam int unsigned TMAX  = 20;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] LR = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b100;
    localparam logic [2:0] LD = 3'b000;

    logic       CK   = 1'b0;
    logic       CLRN = 1'b0;
    logic [2:0] l1   = LR;
    logic [2:0] l2   = LG;
    logic       fm   = 1'b0;
    logic       test = 1'b1;
    logic       ack  = 1'b0;
    logic       FAULT;
    logic [2:0] FAULT_CODE;
    logic [3:0] FAULT_CNT;
    logic [1:0] PH1, PH2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: every sample taken since reset, newest at the back.
    logic [5:0] hist[$];
    int         quiet;
    bit         m_run;
    int         m_fault, m_code, m_cnt, m_ph1, m_ph2;

    traffic_lamp_monitor #(
        .YMIN  (YMIN),
        .TMAX  (TMAX),
        .CNT_W (CNT_W)
    ) dut (
        .CK         (CK),
        .CLRN       (CLRN),
        .GRN1       (l1[2]),
        .YLW1       (l1[1]),
        .RED1       (l1[0]),
        .GRN2       (l2[2]),
        .YLW2       (l2[1]),
        .RED2       (l2[0]),
        .FM         (fm),
        .TEST       (test),
        .ACK        (ack),
        .FAULT      (FAULT),
        .FAULT_CODE (FAULT_CODE),
        .FAULT_CNT  (FAULT_CNT),
        .PH1        (PH1),
        .PH2        (PH2)
    );

    always #5 CK = ~CK;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 RED, 1 GRN, 2 YLW, 3 DARK (none or several lamps lit).
    function automatic int st_of(input logic [2:0] l);
        if ($countones(l) != 1) return 3;
        if (l[0]) return 0;
        if (l[2]) return 1;
        return 2;
    endfunction

    function automatic int yel_run(input int idx, input int d);
        int         k;
        logic [5:0] v;
        k = 0;
        for (int i = idx; i >= 0 && k < 255; i--) begin
            v = hist[i];
            if (st_of((d == 0) ? v[5:3] : v[2:0]) != 2) break;
            k++;
        end
        return k;
    endfunction

    function automatic logic [2:0] adv(input logic [2:0] l);
        case (l)
            LR:      return LG;
            LG:      return LY;
            LY:      return LR;
            default: return LR;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        quiet   = 0;
        m_run   = 1'b0;
        m_fault = 0;
        m_code  = 0;
        m_cnt   = 0;
        m_ph1   = 3;
        m_ph2   = 3;
    endtask

    task automatic model_step();
        int         n, code, a, b;
        logic [5:0] s, p;
        logic [2:0] ls, lp;
        bit         conf, lampf, seqf, ysf, stf;
        if (!m_run) begin
            m_run = 1'b1;
            return;
        end
        n    = hist.size();
        code = 0;
        s    = '0;
        if (n >= 1) begin
            s     = hist[n-1];
            conf  = (s[5] | s[4]) && (s[2] | s[1]);
            lampf = ($countones(s[5:3]) > 1) || ($countones(s[2:0]) > 1)
                 || (!fm && (s[5:3] == 3'b000 || s[2:0] == 3'b000));
            seqf  = 1'b0;
            ysf   = 1'b0;
            stf   = 1'b0;
            p     = '0;
            if (n >= 2) begin
                p = hist[n-2];
                for (int d = 0; d < 2; d++) begin
                    ls = (d == 0) ? s[5:3] : s[2:0];
                    lp = (d == 0) ? p[5:3] : p[2:0];
                    a  = st_of(lp);
                    b  = st_of(ls);
                    if (!fm && !(a == b || (a < 3 && b == (a + 1) % 3))) seqf = 1'b1;
                    if (!fm && a == 2 && b == 0 && yel_run(n - 2, d) < int'(YMIN)) ysf = 1'b1;
                end
            end
            if (fm || test || n < 2 || s != p) begin
                quiet = 0;
            end else begin
                quiet++;
                if (quiet == int'(TMAX)) begin
                    stf   = 1'b1;
                    quiet = 0;
                end
            end
            code = conf ? 1 : lampf ? 2 : seqf ? 3 : ysf ? 4 : stf ? 5 : 0;
        end
        if (code != 0) begin
            if (m_fault == 0 || ack) m_code = code;
            m_fault = 1;
            if (m_cnt < 15) m_cnt++;
        end else if (ack) begin
            m_fault = 0;
            m_code  = 0;
        end
        m_ph1 = (n >= 1) ? st_of(s[5:3]) : 3;
        m_ph2 = (n >= 1) ? st_of(s[2:0]) : 3;
        hist.push_back({l1, l2});
        if (hist.size() > 300) void'(hist.pop_front());
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, ".fault"}, int'(FAULT), m_fault);
        check_eq({pfx, ".code"}, int'(FAULT_CODE), m_code);
        check_eq({pfx, ".cnt"}, int'(FAULT_CNT), m_cnt);
        check_eq({pfx, ".ph1"}, int'(PH1), m_ph1);
        check_eq({pfx, ".ph2"}, int'(PH2), m_ph2);
    endtask

    task automatic step_cycle();
        @(posedge CK);
        model_step();
        @(negedge CK);
        check_outputs("cyc");
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input int cycles);
        l1 = a;
        l2 = b;
        repeat (cycles) step_cycle();
    endtask

    task automatic do_reset();
        @(negedge CK);
        CLRN = 1'b0;
        l1   = LR;
        l2   = LG;
        fm   = 1'b0;
        test = 1'b1;
        ack  = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        @(negedge CK);
        CLRN = 1'b1;
        repeat (3) step_cycle();
        test = 1'b0;
    endtask

    // Dir2 green->yellow->red, then dir1 to green.
    task automatic prefix_to_g1();
        drive(LR, LY, 3);
        drive(LR, LR, 1);
        drive(LG, LR, 3);
    endtask

    initial begin
        int r;
        int hold;
        model_reset();

        // Legal cycle, PH latency
        do_reset();
        drive(LR, LG, 10);
        drive(LR, LY, 4);
        drive(LR, LR, 2);
        l1 = LG;
        step_cycle();
        check_eq("legal_ph1_edge1", int'(PH1), 0);
        step_cycle();
        check_eq("legal_ph1_edge2", int'(PH1), 1);
        check_eq("legal_fault", int'(FAULT), 0);
        check_eq("legal_cnt", int'(FAULT_CNT), 0);

        // Conflict
        do_reset();
        drive(LG, LG, 1);
        drive(LR, LG, 1);
        check_eq("conflict_fault", int'(FAULT), 1);
        check_eq("conflict_code", int'(FAULT_CODE), 1);
        check_eq("conflict_cnt", int'(FAULT_CNT), 1);

        // Short yellow, then minimum legal yellow
        do_reset();
        prefix_to_g1();
        drive(LY, LR, 2);
        drive(LR, LR, 2);
        check_eq("yshort_code", int'(FAULT_CODE), 4);
        do_reset();
        prefix_to_g1();
        drive(LY, LR, 3);
        drive(LR, LR, 2);
        check_eq("yok_fault", int'(FAULT), 0);

        // Stuck, then stuck masked by TEST
        do_reset();
        drive(LR, LG, 15);
        check_eq("stuck_early", int'(FAULT), 0);
        drive(LR, LG, 10);
        check_eq("stuck_code", int'(FAULT_CODE), 5);
        do_reset();
        test = 1'b1;
        drive(LR, LG, 25);
        check_eq("stuck_test_fault", int'(FAULT), 0);

        // Flash mode
        do_reset();
        fm = 1'b1;
        for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? LY : LD, LR, 1);
        check_eq("flash_fault", int'(FAULT), 0);
        drive(LG, LY, 2);
        check_eq("flash_conflict_code", int'(FAULT_CODE), 1);

        // Sticky code, ACK, ACK against an event, mid-run reset
        do_reset();
        prefix_to_g1();
        drive(LR, LR, 2);
        check_eq("sticky_seq_code", int'(FAULT_CODE), 3);
        drive(LG, LR, 1);
        drive(LY, LR, 1);
        drive(LR, LR, 2);
        check_eq("sticky_keep_code", int'(FAULT_CODE), 3);
        check_eq("sticky_cnt", int'(FAULT_CNT), 2);
        ack = 1'b1;
        step_cycle();
        ack = 1'b0;
        check_eq("ack_fault", int'(FAULT), 0);
        check_eq("ack_code", int'(FAULT_CODE), 0);
        check_eq("ack_cnt", int'(FAULT_CNT), 2);
        drive(LR, LY, 1);
        drive(LG, LG, 1);
        check_eq("pre_ack_code", int'(FAULT_CODE), 3);
        ack = 1'b1;
        step_cycle();
        ack = 1'b0;
        check_eq("ack_evt_fault", int'(FAULT), 1);
        check_eq("ack_evt_code", int'(FAULT_CODE), 1);
        #2;
        CLRN = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_fault", int'(FAULT), 0);
        check_eq("midrst_code", int'(FAULT_CODE), 0);
        check_eq("midrst_cnt", int'(FAULT_CNT), 0);
        check_eq("midrst_ph1", int'(PH1), 3);
        check_eq("midrst_ph2", int'(PH2), 3);

        // Random traffic
        do_reset();
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 600 == 599) do_reset();
            if (hold > 0) begin
                hold--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 18) begin
                    if ($urandom_range(0, 1) == 0) l1 = adv(l1);
                    else l2 = adv(l2);
                end else if (r < 22) begin
                    l1 = 3'($urandom_range(0, 7));
                    l2 = 3'($urandom_range(0, 7));
                end else if (r == 99) begin
                    hold = 25;
                end
            end
            if ($urandom_range(0, 29) == 0) fm = ~fm;
            if ($urandom_range(0, 29) == 0) test = ~test;
            ack = ($urandom_range(0, 7) == 0);
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
